// File: rtl/wb_retire.sv
// wb_retire: write-back / retirement stage.
//
// Execute results enter a small FIFO. The FIFO head is popped every cycle
// the FIFO is not empty, so the stage retires or discards one result per
// cycle.
//
// A popped result is handled in one of two ways:
//   - Its tag matches cur_tag: it retires. The register-bank write and the
//     one-hot release are issued on the next cycle. A retired jump also
//     redirects fetch and advances cur_tag.
//   - Its tag does not match: it is discarded and discard_cnt counts it.
//
// Ports:
//   clk, reset                    clock; asynchronous active-low reset
//   in_valid/in_ready             result handshake (in_ready = FIFO not full)
//   in_tag/in_rd/in_data          result payload: stream tag, dest reg, value
//   in_jump/in_target             taken branch/jump and its target address
//   rf_we/rf_addr/rf_data         register-bank write port
//   release_vec                   one-hot unlock of the retired destination
//   cur_tag                       tag currently accepted for retirement
//   jump_out/new_pc               one-cycle fetch redirect
//   discard_cnt                   saturating count of discarded results
module wb_retire #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [4:0]       in_rd,
   input  logic [31:0]      in_data,
   input  logic             in_jump,
   input  logic [31:0]      in_target,
   output logic             rf_we,
   output logic [4:0]       rf_addr,
   output logic [31:0]      rf_data,
   output logic [31:0]      release_vec,
   output logic [TAG_W-1:0] cur_tag,
   output logic             jump_out,
   output logic [31:0]      new_pc,
   output logic [15:0]      discard_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [4:0]       rd;
      logic [31:0]      data;
      logic             jump;
      logic [31:0]      target;
   } ent_t;

   typedef enum logic {RUN, FLUSH} state_t;

   ent_t          mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic          push, pop;
   ent_t          head;
   logic          retire, discard, take_jump;
   state_t        state_q, state_d;

   assign in_ready = (count != FULL_CNT);
   // A full FIFO refuses the offer even though a pop frees a slot this
   // cycle; accepting it would need a same-cycle bypass path.
   assign push     = in_valid && in_ready;
   assign pop      = (count != '0);
   assign head     = mem[rd_ptr];

   // ---------------- result FIFO ----------------
   // The storage array is left unreset. Clearing count is enough to make
   // every stale entry unreachable.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{in_tag, in_rd, in_data, in_jump, in_target};
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------- retire / flush FSM ----------------
   // cur_tag advances on the same edge that issues the redirect. The next
   // pop is therefore already compared against the new stream tag, and
   // every wrong-path result behind the jump is discarded.
   always_comb begin
      retire    = pop && (head.tag == cur_tag);
      discard   = pop && (head.tag != cur_tag);
      take_jump = retire && head.jump;
      state_d   = state_q;
      case (state_q)
         RUN:   if (take_jump) state_d = FLUSH;
         // A retired jump found while flushing starts a new flush.
         FLUSH: if (retire)    state_d = head.jump ? FLUSH : RUN;
         default:              state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= RUN;
      else        state_q <= state_d;
   end

   // ---------------- registered outputs ----------------
   // rf_addr, rf_data and new_pc keep their last value between events.
   // Only rf_we and jump_out mark when those values are meaningful.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rf_we       <= 1'b0;
         rf_addr     <= '0;
         rf_data     <= '0;
         release_vec <= '0;
         cur_tag     <= '0;
         jump_out    <= 1'b0;
         new_pc      <= '0;
         discard_cnt <= '0;
      end else begin
         // Register 0 is never written, so its retirement releases nothing.
         rf_we       <= retire && (head.rd != 5'd0);
         release_vec <= (retire && head.rd != 5'd0) ? (32'd1 << head.rd) : 32'd0;
         jump_out    <= take_jump;
         if (retire) begin
            rf_addr <= head.rd;
            rf_data <= head.data;
         end
         if (take_jump) begin
            new_pc  <= head.target;
            cur_tag <= cur_tag + TAG_W'(1);
         end
         if (discard && discard_cnt != 16'hFFFF)
            discard_cnt <= discard_cnt + 16'd1;
      end
   end

endmodule
